cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares the two common data bus channels (data[0], data[1]) between REQ_COUNT execution units.
//   Grants up to two requesters per cycle, round-robin, and registers the winners onto the CDB.
//   Drops speculative results when a tag flush is signalled.
//   Sits between the execution units and every CDB consumer (reservation stations, ROB, register file).
// PARAMETERS
//   REQ_COUNT  4   number of requesting execution units, 2..8
//   DATA_W     32  result width
// PORTS
//   clock          in   1               system clock, rising edge
//   reset          in   1               synchronous, active-high
//   i_delete_tag   in   1               flush: kill every result with tag=1
//   i_req          in   REQ_COUNT       requester r has a valid result
//   i_result       in   REQ_COUNT*DATA_W result payload per requester
//   i_arn          in   REQ_COUNT*6     architectural destination per requester
//   i_rrn          in   REQ_COUNT*6     renamed destination per requester
//   i_tag          in   REQ_COUNT       speculative tag per requester
//   o_ack          out  REQ_COUNT       request consumed (granted or killed) this cycle
//   o_cdb_valid    out  2               channel c carries a result
//   o_cdb_result   out  2*DATA_W        channel payload
//   o_cdb_arn      out  2*6             channel architectural register
//   o_cdb_rrn      out  2*6             channel renamed register
//   o_cdb_tag      out  2               channel tag
// BEHAVIOUR
//   Handshake
//   - The requester holds i_req and its payload stable until o_ack.
//   - o_ack is combinational in the same cycle as acceptance.
//   - The requester may deassert i_req or present a new result in the cycle after o_ack.
//   Selection
//   - Scan requesters starting at rr_ptr, wrapping modulo REQ_COUNT.
//   - First requesting index -> channel 0; second -> channel 1.
//   - At most 2 acks from grants per cycle; requesters not granted get no ack.
//   Latency
//   - Granted payload appears on o_cdb_* at the next rising edge (1-cycle register), valid for exactly one cycle.
//   - o_cdb_valid is low in any cycle following zero grants.
//   Pointer
//   - After any grant, rr_ptr <= (index of the last granted requester + 1) mod REQ_COUNT.
//   - rr_ptr is unchanged when nothing is granted.
//   Flush (i_delete_tag=1)
//   - Every requester with i_req&&i_tag is acked (killed) and is never broadcast.
//   - Requesters with tag=0 still arbitrate normally.
//   - Output register entries with o_cdb_tag=1 clear their valid bit at the edge instead of broadcasting.
//   - rr_ptr advances only on real grants.
//   Reset
//   - o_cdb_valid=0, o_cdb_result/arn/rrn/tag=0, rr_ptr=0.
//   - o_ack is 0 while reset is high, regardless of i_req.
//   - Reset asserted mid-transfer drops the registered entry; requesters keep holding their requests.
//   Boundaries
//   - Exactly 1 request: goes to channel 0; channel 1 stays invalid.
//   - More than 2 requests: the excess waits. Round-robin bounds the wait to ceil((REQ_COUNT-1)/2) grant cycles.
//   - rr_ptr wrap from REQ_COUNT-1 to 0 is seamless.
// CONFIGURATION
//   CDB_ARB_STATS_EN defined:
//   - Adds output o_conflict_cnt [31:0]. It counts cycles with more than 2 live (non-killed) requests.
//   - It saturates at 32'hFFFF_FFFF and clears on reset.
//   CDB_ARB_STATS_EN undefined:
//   - The port and counter are absent; arbitration behaviour is identical.
// STRUCTURE
//   pkg_defines gains:
//   - typedef struct packed cdb_entry_t {result, arn, rrn, tag, valid}
//   - localparam int CDB_CHANNELS = 2
//   Sub-module rr_pick2:
//   - Purely combinational.
//   - Inputs: request vector and rr_ptr.
//   - Outputs: two one-hot grants, grant-valid bits and the last-granted index.
//   cdb_arbiter holds rr_ptr, the output registers, the flush kill logic and the optional counter.
// TESTING
//   1. reset=1 with i_req=4'b1111 -> o_ack=0, o_cdb_valid=2'b00.
//      Release reset -> req0 on ch0, req1 on ch1 one cycle later, rr_ptr=2.
//   2. i_req=4'b0100 only, result 32'hDEAD_BEEF, rrn=6'd9 -> o_ack=4'b0100 same cycle;
//      next cycle o_cdb_valid=2'b01, o_cdb_result[0]=32'hDEAD_BEEF, o_cdb_rrn[0]=9.
//   3. All 4 requesting, held continuously:
//      -> cycle grants {0,1},{2,3},{0,1}; no requester waits more than 1 grant cycle.
//   4. i_delete_tag=1 with i_req=4'b0011, i_tag=4'b0001:
//      -> o_ack=4'b0011; next cycle ch0 carries req1 only; req0 never broadcast.
//   5. Grant of tag=1 result, then i_delete_tag=1 in the following cycle:
//      -> o_cdb_valid for that channel is 0 after the edge.
//   6. With CDB_ARB_STATS_EN: 10 cycles of 3 live requests -> o_conflict_cnt=10.
//      Preloaded 32'hFFFF_FFFF stays saturated.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
// Holds the broadcast entry layout and the pointer-width helper used by the arbiter and picker.
package cdb_arbiter_pkg;

  localparam int CDB_CHANNELS = 2;
  localparam int CDB_DATA_W   = 32;
  localparam int REG_W        = 6;

  // The result field width must match the arbiter's DATA_W parameter.
  typedef struct packed {
    logic [CDB_DATA_W-1:0] result;
    logic [REG_W-1:0]      arn;
    logic [REG_W-1:0]      rrn;
    logic                  tag;
    logic                  valid;
  } cdb_entry_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Combinational round-robin picker: selects up to two requesters per cycle.
// The scan starts at ptr and wraps; the first hit goes to channel 0, the second to channel 1.
module rr_pick2
  import cdb_arbiter_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int PTR_W     = ptr_width(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0]                    req,
  input  logic [PTR_W-1:0]                        ptr,
  output logic [CDB_CHANNELS-1:0][REQ_COUNT-1:0]  grant,
  output logic [CDB_CHANNELS-1:0]                 grant_valid,
  output logic [PTR_W-1:0]                        last_idx
);

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    grant       = '0;
    grant_valid = '0;
    last_idx    = '0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= REQ_COUNT) begin
        idx = idx - REQ_COUNT;
      end
      sel = PTR_W'(idx);
      if (req[sel]) begin
        if (!grant_valid[0]) begin
          grant[0][sel]  = 1'b1;
          grant_valid[0] = 1'b1;
          last_idx       = sel;
        end else if (!grant_valid[1]) begin
          grant[1][sel]  = 1'b1;
          grant_valid[1] = 1'b1;
          last_idx       = sel;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-channel common data bus arbiter with round-robin grants and speculative-tag flush.
// Optional build macro CDB_ARB_STATS_EN adds o_conflict_cnt, a saturating count of oversubscribed cycles.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int DATA_W    = CDB_DATA_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_delete_tag,
  input  logic [REQ_COUNT-1:0]           i_req,
  input  logic [REQ_COUNT*DATA_W-1:0]    i_result,
  input  logic [REQ_COUNT*REG_W-1:0]     i_arn,
  input  logic [REQ_COUNT*REG_W-1:0]     i_rrn,
  input  logic [REQ_COUNT-1:0]           i_tag,
  output logic [REQ_COUNT-1:0]           o_ack,
  output logic [CDB_CHANNELS-1:0]        o_cdb_valid,
  output logic [CDB_CHANNELS*DATA_W-1:0] o_cdb_result,
  output logic [CDB_CHANNELS*REG_W-1:0]  o_cdb_arn,
  output logic [CDB_CHANNELS*REG_W-1:0]  o_cdb_rrn,
  output logic [CDB_CHANNELS-1:0]        o_cdb_tag
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                    o_conflict_cnt
`endif
);

  localparam int PTR_W = ptr_width(REQ_COUNT);

  logic [PTR_W-1:0]                       rr_ptr;
  logic [PTR_W-1:0]                       last_idx;
  logic [REQ_COUNT-1:0]                   killed;
  logic [REQ_COUNT-1:0]                   live;
  logic [CDB_CHANNELS-1:0][REQ_COUNT-1:0] grant;
  logic [CDB_CHANNELS-1:0]                grant_valid;
  cdb_entry_t                             chan_q [CDB_CHANNELS];
  cdb_entry_t                             chan_d [CDB_CHANNELS];

  // Speculative results are consumed without ever reaching the bus while a flush is active.
  assign killed = i_delete_tag ? (i_req & i_tag) : '0;
  assign live   = i_req & ~killed;

  rr_pick2 #(
    .REQ_COUNT (REQ_COUNT),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req         (live),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .last_idx    (last_idx)
  );

  assign o_ack = reset ? '0 : (grant[0] | grant[1] | killed);

  // Channel entries are rebuilt from fresh grants every cycle, so a tagged entry
  // that is already on the bus never survives into the next cycle.
  always_comb begin
    for (int c = 0; c < CDB_CHANNELS; c++) begin
      chan_d[c] = '0;
      for (int r = 0; r < REQ_COUNT; r++) begin
        if (grant[c][r]) begin
          chan_d[c].result = CDB_DATA_W'(i_result[r*DATA_W +: DATA_W]);
          chan_d[c].arn    = i_arn[r*REG_W +: REG_W];
          chan_d[c].rrn    = i_rrn[r*REG_W +: REG_W];
          chan_d[c].tag    = i_tag[r];
          chan_d[c].valid  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int c = 0; c < CDB_CHANNELS; c++) begin
        chan_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CDB_CHANNELS; c++) begin
        chan_q[c] <= chan_d[c];
      end
      if (|grant_valid) begin
        rr_ptr <= (last_idx == PTR_W'(REQ_COUNT - 1)) ? '0 : last_idx + PTR_W'(1);
      end
    end
  end

  always_comb begin
    o_cdb_valid  = '0;
    o_cdb_result = '0;
    o_cdb_arn    = '0;
    o_cdb_rrn    = '0;
    o_cdb_tag    = '0;
    for (int c = 0; c < CDB_CHANNELS; c++) begin
      o_cdb_valid[c]                    = chan_q[c].valid;
      o_cdb_result[c*DATA_W +: DATA_W]  = DATA_W'(chan_q[c].result);
      o_cdb_arn[c*REG_W +: REG_W]       = chan_q[c].arn;
      o_cdb_rrn[c*REG_W +: REG_W]       = chan_q[c].rrn;
      o_cdb_tag[c]                      = chan_q[c].tag;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] conflict_cnt;

  // Only live requests count: killed results do not compete for a channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (($countones(live) > 2) && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign o_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected acks and bus entries,
// and two monitor processes compare them against the DUT cycle by cycle.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            i_delete_tag;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_result;
  logic [N*6-1:0]  i_arn;
  logic [N*6-1:0]  i_rrn;
  logic [N-1:0]    i_tag;
  logic [N-1:0]    o_ack;
  logic [1:0]      o_cdb_valid;
  logic [2*DW-1:0] o_cdb_result;
  logic [11:0]     o_cdb_arn;
  logic [11:0]     o_cdb_rrn;
  logic [1:0]      o_cdb_tag;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]     conflict_cnt;
`endif

  typedef struct packed {
    logic            full;
    logic [1:0]      valid;
    logic [1:0][31:0] res;
    logic [1:0][5:0] arn;
    logic [1:0][5:0] rrn;
    logic [1:0]      tag;
  } exp_t;

  exp_t         cdb_q [$];
  logic [N-1:0] ack_q [$];

  logic [31:0] res_tb [N];
  logic [5:0]  arn_tb [N];
  logic [5:0]  rrn_tb [N];

  int compared   = 0;
  int mismatched = 0;

  cdb_arbiter #(
    .REQ_COUNT (N),
    .DATA_W    (DW)
  ) dut (
`ifdef CDB_ARB_STATS_EN
    .o_conflict_cnt (conflict_cnt),
`endif
    .clock        (clock),
    .reset        (reset),
    .i_delete_tag (i_delete_tag),
    .i_req        (i_req),
    .i_result     (i_result),
    .i_arn        (i_arn),
    .i_rrn        (i_rrn),
    .i_tag        (i_tag),
    .o_ack        (o_ack),
    .o_cdb_valid  (o_cdb_valid),
    .o_cdb_result (o_cdb_result),
    .o_cdb_arn    (o_cdb_arn),
    .o_cdb_rrn    (o_cdb_rrn),
    .o_cdb_tag    (o_cdb_tag)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ch0/ch1 give the requester index expected on each channel next cycle, -1 for idle.
  task automatic applyStimulus(input logic rst, input logic del, input logic [N-1:0] req,
                               input logic [N-1:0] tag, input logic [N-1:0] exp_ack,
                               input int ch0, input int ch1);
    exp_t       e;
    int         ch [2];
    logic [1:0] sel;
    @(negedge clock);
    reset        = rst;
    i_delete_tag = del;
    i_req        = req;
    i_tag        = tag;
    for (int r = 0; r < N; r++) begin
      i_result[r*DW +: DW] = res_tb[r];
      i_arn[r*6 +: 6]      = arn_tb[r];
      i_rrn[r*6 +: 6]      = rrn_tb[r];
    end
    ack_q.push_back(exp_ack);
    e      = '0;
    e.full = rst;
    ch[0]  = ch0;
    ch[1]  = ch1;
    for (int c = 0; c < 2; c++) begin
      if (ch[c] >= 0) begin
        sel        = 2'(ch[c]);
        e.valid[c] = 1'b1;
        e.res[c]   = res_tb[sel];
        e.arn[c]   = arn_tb[sel];
        e.rrn[c]   = rrn_tb[sel];
        e.tag[c]   = tag[sel];
      end
    end
    cdb_q.push_back(e);
  endtask

  initial begin : ack_monitor
    logic [N-1:0] exp_ack;
    forever begin
      @(negedge clock);
      #3;
      if (ack_q.size() > 0) begin
        exp_ack = ack_q.pop_front();
        checkOutput("ack", 64'(o_ack), 64'(exp_ack));
      end
    end
  end

  initial begin : cdb_monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (cdb_q.size() > 0) begin
        e = cdb_q.pop_front();
        checkOutput("cdb_valid", 64'(o_cdb_valid), 64'(e.valid));
        if (e.full) begin
          checkOutput("reset_result", o_cdb_result, 64'd0);
          checkOutput("reset_arn_rrn_tag", 64'({o_cdb_arn, o_cdb_rrn, o_cdb_tag}), 64'd0);
        end
        for (int c = 0; c < 2; c++) begin
          if (e.valid[c]) begin
            checkOutput($sformatf("ch%0d_result", c), 64'(o_cdb_result[c*DW +: DW]), 64'(e.res[c]));
            checkOutput($sformatf("ch%0d_arn", c), 64'(o_cdb_arn[c*6 +: 6]), 64'(e.arn[c]));
            checkOutput($sformatf("ch%0d_rrn", c), 64'(o_cdb_rrn[c*6 +: 6]), 64'(e.rrn[c]));
            checkOutput($sformatf("ch%0d_tag", c), 64'(o_cdb_tag[c]), 64'(e.tag[c]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    reset        = 1'b1;
    i_delete_tag = 1'b0;
    i_req        = '0;
    i_tag        = '0;
    i_result     = '0;
    i_arn        = '0;
    i_rrn        = '0;
    for (int r = 0; r < N; r++) begin
      res_tb[r] = 32'h1000_0000 + 32'(r) * 32'h11;
      arn_tb[r] = 6'(r + 1);
      rrn_tb[r] = 6'(r + 10);
    end

    // Reset holds acks low even with every requester active.
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, -1, -1);
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, -1, -1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b1100, 4'b0000, 4'b1100,  2,  3);

    res_tb[2] = 32'hDEAD_BEEF;
    rrn_tb[2] = 6'd9;
    applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100,  2, -1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1);
    applyStimulus(1'b0, 1'b0, 4'b1000, 4'b0000, 4'b1000,  3, -1);

    // Pointer has wrapped to 0; all four held alternate pairs.
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1100,  2,  3);
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1100,  2,  3);

    applyStimulus(1'b0, 1'b1, 4'b0011, 4'b0001, 4'b0011,  1, -1);
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0101, 4'b1111,  3,  1);
    applyStimulus(1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100,  2, -1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, -1, -1);

    // Kill-only cycle must leave the pointer at 3, so 3 beats 2 next.
    applyStimulus(1'b0, 1'b1, 4'b0011, 4'b0011, 4'b0011, -1, -1);
    applyStimulus(1'b0, 1'b0, 4'b1100, 4'b0000, 4'b1100,  3,  2);

    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, -1, -1);
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b1010, 4'b0000, 4'b1010,  3,  1);

    // Fresh reset, then ten cycles with three live requesters.
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0101,  2,  0);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0110,  1,  2);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0101,  2,  0);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0110,  1,  2);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0101,  2,  0);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0110,  1,  2);
    applyStimulus(1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0011,  0,  1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1);

    for (int i = 0; i < 8; i++) begin
      if (cdb_q.size() == 0 && ack_q.size() == 0) break;
      @(posedge clock);
    end
    @(negedge clock);
    checkOutput("queues_drained", 64'(cdb_q.size() + ack_q.size()), 64'd0);

`ifdef CDB_ARB_STATS_EN
    checkOutput("conflict_cnt", 64'(conflict_cnt), 64'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
